// File: rtl/hub75_if.sv
// HUB75-style panel bus: row address, two half-panel RGB bits, OE, LAT and shift clock.
interface hub75_if;
  logic A;
  logic B;
  logic C;
  logic D;
  logic R0;
  logic G0;
  logic B0;
  logic R1;
  logic G1;
  logic B1;
  logic OE;
  logic LAT;
  logic clk_shft;

  modport master (
    output A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT, clk_shft
  );

  modport slave (
    input A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT, clk_shft
  );
endinterface

// File: rtl/hub75_capture.sv
// Panel-side capture of the HUB75 bus: rebuilds the displayed 32 x COLS frame
// in a row store, counts frames and flags row-length and OE protocol errors.
module hub75_capture #(
  parameter int unsigned COLS  = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  hub75_if.slave                bus,
  input  logic [4:0]            rd_row,
  output logic [3*COLS-1:0]     rd_data,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  err_len,
  output logic                  err_oe,
  input  logic                  clr_err
);

  localparam int unsigned ROW_W  = 3 * COLS;
  localparam int unsigned ROWS   = 32;
  localparam int unsigned COL_CW = $clog2(COLS + 2);

  logic              s_a, s_b, s_c, s_d;
  logic              s_r0, s_g0, s_b0, s_r1, s_g1, s_b1;
  logic              s_oe, s_lat, s_clk_shft;
  logic              d_lat, d_clk_shft;

  logic [ROW_W-1:0]  upper;
  logic [ROW_W-1:0]  lower;
  logic [COL_CW-1:0] col_cnt;
  logic [ROW_W-1:0]  store [ROWS];

  logic              shift_c;
  logic              latch_c;
  logic [3:0]        addr_c;
  logic [ROW_W-1:0]  upper_c;
  logic [ROW_W-1:0]  lower_c;
  logic [COL_CW-1:0] col_c;
  logic              set_len_c;
  logic              set_oe_c;

  // Single register stage for the bus pins plus a delayed copy of the strobes for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      {s_a, s_b, s_c, s_d}                  <= '0;
      {s_r0, s_g0, s_b0, s_r1, s_g1, s_b1}  <= '0;
      s_oe                                  <= 1'b0;
      s_lat                                 <= 1'b0;
      s_clk_shft                            <= 1'b0;
      d_lat                                 <= 1'b0;
      d_clk_shft                            <= 1'b0;
    end else begin
      {s_a, s_b, s_c, s_d}                  <= {bus.A, bus.B, bus.C, bus.D};
      {s_r0, s_g0, s_b0}                    <= {bus.R0, bus.G0, bus.B0};
      {s_r1, s_g1, s_b1}                    <= {bus.R1, bus.G1, bus.B1};
      s_oe                                  <= bus.OE;
      s_lat                                 <= bus.LAT;
      s_clk_shft                            <= bus.clk_shft;
      d_lat                                 <= s_lat;
      d_clk_shft                            <= s_clk_shft;
    end
  end

  // Shift result is computed first so a coincident latch commits the new pixel.
  always_comb begin
    shift_c   = s_clk_shft & ~d_clk_shft;
    latch_c   = s_lat & ~d_lat;
    addr_c    = {s_d, s_c, s_b, s_a};
    upper_c   = upper;
    lower_c   = lower;
    col_c     = col_cnt;
    set_len_c = 1'b0;
    set_oe_c  = 1'b0;
    if (shift_c) begin
      upper_c = {upper[ROW_W-4:0], s_r0, s_g0, s_b0};
      lower_c = {lower[ROW_W-4:0], s_r1, s_g1, s_b1};
      if (col_cnt != COL_CW'(COLS + 1)) begin
        col_c = col_cnt + COL_CW'(1);
      end
    end
    if (latch_c) begin
      set_len_c = (col_c != COL_CW'(COLS));
      set_oe_c  = ~s_oe;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      upper   <= '0;
      lower   <= '0;
      col_cnt <= '0;
    end else begin
      upper   <= upper_c;
      lower   <= lower_c;
      col_cnt <= latch_c ? '0 : col_c;
    end
  end

  // Row store and registered readback; a same-cycle read returns the pre-commit row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(ROWS); i++) begin
        store[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (latch_c) begin
        store[{1'b0, addr_c}] <= upper_c;
        store[{1'b1, addr_c}] <= lower_c;
      end
      rd_data <= store[rd_row];
    end
  end

  // Frame accounting and sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_len    <= 1'b0;
      err_oe     <= 1'b0;
    end else begin
      frame_done <= latch_c && (addr_c == 4'd15);
      if (latch_c && (addr_c == 4'd15)) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (set_len_c) begin
        err_len <= 1'b1;
      end else if (clr_err) begin
        err_len <= 1'b0;
      end
      if (set_oe_c) begin
        err_oe <= 1'b1;
      end else if (clr_err) begin
        err_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: drives the panel bus row by row and checks
// the rebuilt frame, frame counting and the error flags against hand-derived values.
module tb_hub75_capture;

  localparam int unsigned COLS  = 64;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ROW_W = 3 * COLS;

  logic              clk;
  logic              rst;
  logic [4:0]        rd_row;
  logic [ROW_W-1:0]  rd_data;
  logic              frame_done;
  logic [CNT_W-1:0]  frame_cnt;
  logic              err_len;
  logic              err_oe;
  logic              clr_err;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;

  hub75_if bus ();

  hub75_capture #(.COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_len    (err_len),
    .err_oe     (err_oe),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_px(input logic [2:0] up, input logic [2:0] lo);
    {bus.R0, bus.G0, bus.B0} = up;
    {bus.R1, bus.G1, bus.B1} = lo;
  endtask

  task automatic set_addr(input logic [3:0] a);
    {bus.D, bus.C, bus.B, bus.A} = a;
  endtask

  task automatic shift_px(input logic [2:0] up, input logic [2:0] lo);
    set_px(up, lo);
    bus.clk_shft = 1'b1;
    tick();
    bus.clk_shft = 1'b0;
    tick();
  endtask

  task automatic shift_n(input int n, input logic [2:0] up, input logic [2:0] lo);
    for (int i = 0; i < n; i++) shift_px(up, lo);
  endtask

  // Returns one cycle after the commit edge, i.e. in the frame_done cycle.
  task automatic latch(input logic [3:0] a, input logic oe, input logic clr);
    set_addr(a);
    bus.OE  = oe;
    bus.LAT = 1'b1;
    tick();
    bus.LAT = 1'b0;
    clr_err = clr;
    tick();
    clr_err = 1'b0;
    bus.OE  = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] r, input logic [ROW_W-1:0] exp);
    rd_row = r;
    tick();
    check(tag, rd_data, exp);
  endtask

  function automatic logic [ROW_W-1:0] fill(input logic [2:0] v);
    return {COLS{v}};
  endfunction

  function automatic logic [2:0] up_pix(input int a, input int i);
    return 3'(a + i);
  endfunction

  function automatic logic [2:0] lo_pix(input int a, input int i);
    return ~3'(a + i);
  endfunction

  // First shifted pixel (i = 0) lands in column COLS-1.
  function automatic logic [ROW_W-1:0] frame_row(input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      v[3*c +: 3] = (r < 16) ? up_pix(r, int'(COLS) - 1 - c) : lo_pix(r - 16, int'(COLS) - 1 - c);
    end
    return v;
  endfunction

  initial begin
    logic [ROW_W-1:0] e;
    rst     = 1'b0;
    rd_row  = '0;
    clr_err = 1'b0;
    set_addr(4'd0);
    set_px(3'd0, 3'd0);
    bus.OE       = 1'b1;
    bus.LAT      = 1'b0;
    bus.clk_shft = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    check("rst_rd_data", rd_data, '0);
    check("rst_frame_done", 192'(frame_done), '0);
    check("rst_frame_cnt", 192'(frame_cnt), '0);
    check("rst_err_len", 192'(err_len), '0);
    check("rst_err_oe", 192'(err_oe), '0);

    // Populate a row, then reset mid-row and confirm the store is cleared.
    shift_n(64, 3'd7, 3'd7);
    latch(4'd5, 1'b1, 1'b0);
    read_chk("pre_rst_row5", 5'd5, fill(3'd7));
    shift_n(10, 3'd3, 3'd3);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check("mid_rst_frame_cnt", 192'(frame_cnt), '0);
    check("mid_rst_err_len", 192'(err_len), '0);
    for (int r = 0; r < 32; r++) read_chk($sformatf("rst_row%0d", r), 5'(r), '0);
    shift_n(64, 3'd0, 3'd0);
    latch(4'd0, 1'b1, 1'b0);
    check("post_rst_err_len", 192'(err_len), '0);

    // Single row: only the first upper pixel red, lower all green.
    for (int i = 0; i < 64; i++) shift_px((i == 0) ? 3'b100 : 3'b000, 3'b010);
    latch(4'd3, 1'b1, 1'b0);
    e = '0;
    e[191] = 1'b1;
    read_chk("single_row3", 5'd3, e);
    read_chk("single_row19", 5'd19, fill(3'b010));
    check("single_err_len", 192'(err_len), '0);
    check("single_err_oe", 192'(err_oe), '0);

    // Full frame with a per-row, per-column pattern.
    for (int a = 0; a < 16; a++) begin
      for (int i = 0; i < 64; i++) shift_px(up_pix(a, i), lo_pix(a, i));
      latch(4'(a), 1'b1, 1'b0);
      if (a == 15) begin
        check("frame_done_pulse", 192'(frame_done), 192'(1));
        tick();
        check("frame_done_drop", 192'(frame_done), '0);
      end
    end
    check("frame_done_count", 192'(fd_cnt), 192'(1));
    check("frame_cnt_1", 192'(frame_cnt), 192'(1));
    check("frame_err_len", 192'(err_len), '0);
    check("frame_err_oe", 192'(err_oe), '0);
    for (int r = 0; r < 32; r++) read_chk($sformatf("frame_row%0d", r), 5'(r), frame_row(r));

    // Short row: column 63 keeps the old column-0 pixel since the registers are not cleared.
    shift_n(63, 3'd7, 3'd0);
    latch(4'd2, 1'b1, 1'b0);
    check("short_err_len", 192'(err_len), 192'(1));
    e = fill(3'd7);
    e[191:189] = 3'd6;
    read_chk("short_row2", 5'd2, e);
    e = fill(3'd0);
    e[191:189] = 3'd1;
    read_chk("short_row18", 5'd18, e);
    shift_n(65, 3'd1, 3'd1);
    latch(4'd4, 1'b1, 1'b0);
    check("long_err_len", 192'(err_len), 192'(1));
    read_chk("long_row4", 5'd4, fill(3'd1));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err_len", 192'(err_len), '0);

    // OE low at latch, with a coincident clear that must lose.
    shift_n(64, 3'd0, 3'd0);
    latch(4'd6, 1'b0, 1'b1);
    check("oe_err_oe", 192'(err_oe), 192'(1));
    check("oe_err_len", 192'(err_len), '0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err_oe", 192'(err_oe), '0);

    // 64th pixel arrives on the same sample as the latch rise.
    shift_n(63, 3'd1, 3'd2);
    set_px(3'd4, 3'd2);
    set_addr(4'd8);
    bus.OE       = 1'b1;
    bus.clk_shft = 1'b1;
    bus.LAT      = 1'b1;
    tick();
    bus.clk_shft = 1'b0;
    bus.LAT      = 1'b0;
    tick();
    check("simul_err_len", 192'(err_len), '0);
    e = fill(3'd1);
    e[2:0] = 3'd4;
    read_chk("simul_row8", 5'd8, e);
    read_chk("simul_row24", 5'd24, fill(3'd2));

    // Read of the row being committed returns old data first.
    shift_n(64, 3'd5, 3'd5);
    set_addr(4'd7);
    bus.LAT = 1'b1;
    tick();
    bus.LAT = 1'b0;
    rd_row  = 5'd7;
    tick();
    check("collide_old", rd_data, frame_row(7));
    tick();
    check("collide_new", rd_data, fill(3'd5));

    // Frame counter wrap: 255 more addr-15 commits after the first frame.
    for (int n = 0; n < 254; n++) latch(4'd15, 1'b1, 1'b0);
    check("frame_cnt_255", 192'(frame_cnt), 192'(255));
    latch(4'd15, 1'b1, 1'b0);
    check("frame_cnt_wrap", 192'(frame_cnt), '0);
    tick();
    check("frame_done_total", 192'(fd_cnt), 192'(256));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hub75_capture.md
# hub75_capture

Receive-side model of the LED-matrix panel: samples the HUB75-style bus (A–D, R0/G0/B0, R1/G1/B1, OE, LAT, clk_shft) that the matrix driver emits and rebuilds the displayed 32 x COLS RGB frame in an internal row store. It sits beside the matrix driver in simulation and on-chip debug builds, giving the bench and the score/debug logic a readable copy of what the panel would show. It also flags protocol violations.

## Interface
- COLS, 64: pixels per row; shift register width 3*COLS
- CNT_W, 8: width of frame counter
- clk  in  1  system clock; the same clock that drives clk_div
- rst  in  1  synchronous, active-low reset
- A, B, C, D  in  1 each  row-pair address, D = MSB
- R0, G0, B0  in  1 each  upper-half pixel bits
- R1, G1, B1  in  1 each  lower-half pixel bits
- OE  in  1  output enable, active-low; panel lit when 0
- LAT  in  1  latch strobe
- clk_shft  in  1  shift clock from clk_div
- rd_row  in  5  readback row, 0–31
- rd_data  out  3*COLS  pixel c at bits [3c+2:3c] = {R,G,B}
- frame_done  out  1  one-cycle pulse, row pair 15 committed
- frame_cnt  out  CNT_W  committed frames, wraps
- err_len  out  1  sticky: latch with column count != COLS
- err_oe  out  1  sticky: latch rising while OE = 0
- clr_err  in  1  clears err_len/err_oe

## Operation
- Input stage: all bus pins are registered once into s_*. There is no metastability synchroniser because the bus comes from the clk domain. s_clk_shft and s_LAT are registered again for edge detection.
- Shift: on a detected clk_shft rising edge, the upper and lower shift registers shift toward higher column index. {s_R0,s_G0,s_B0} enters column 0 of the upper register; {s_R1,s_G1,s_B1} enters column 0 of the lower register. After COLS shifts, the first-shifted pixel sits in column COLS-1.
- col_cnt increments per shift and saturates at COLS+1.
- Latch: on a detected LAT rising edge, with addr = {s_D,s_C,s_B,s_A}:
  - write the upper register to row addr and the lower register to row addr+16;
  - clear col_cnt. Shift registers are not cleared.
  - if col_cnt != COLS, set err_len; the rows are still written.
  - if s_OE == 0, set err_oe.
- Frame: a commit to addr 15 pulses frame_done and increments frame_cnt (mod 2^CNT_W).
- Same-sample clk_shft rise and LAT rise: the shift happens first. The committed row and the col_cnt check both include the new pixel.
- clr_err: clears both error flags. If the same cycle also sets an error, the set wins.
- Readback: rd_data <= store[rd_row], registered. Reading a row in the same cycle it is committed returns the old data.
- Reset (rst = 0 at a clk edge), which may arrive mid-row:
  - clears the store to 0, both shift registers, col_cnt, frame_cnt, err_len, err_oe, frame_done, rd_data, and the input/edge registers;
  - a partial row is discarded.

## Timing
- Reset values of every output: rd_data = 0, frame_done = 0, frame_cnt = 0, err_len = 0, err_oe = 0.
- A pin transition present before clk edge k is held in s_* after edge k. The edge is detected combinationally in cycle k..k+1, and the shift register or store updates at edge k+1. Pin-to-state latency is 2 clk edges.
- frame_done is high for exactly the cycle after the committing edge. The new row is readable via rd_row from that cycle; rd_data reflects it one edge later.
- clk_shft and LAT must each stay high and low for at least 1 clk cycle. Faster toggling is undefined.
- Levels of A–D, colour and OE are taken from the same s_* sample as the detected edge.

## Test plan
- Reset: hold rst = 0 for 2 clocks mid-row after 10 shifts → all outputs 0; rd_data for rows 0–31 is all 0; the next 64-shift row latches with err_len = 0.
- Single row: 64 shifts, with only the first upper pixel set (R0 = 1) and the lower pixels G1 = 1, then LAT with addr 3 →
  - rd_row = 3 gives bit 191 = 1 and all other bits 0;
  - rd_row = 19 gives G set in all 64 columns;
  - err_len = 0.
- Full frame: drive addr 0..15 with a per-row pattern, OE = 1 at each latch →
  - exactly one frame_done, 1 cycle after the addr-15 commit;
  - frame_cnt = 1;
  - all 32 rows read back correctly.
- Length error: 63 shifts then latch → err_len = 1 and the row is written. Then 65 shifts then latch → err_len stays 1. Then clr_err → err_len = 0.
- OE violation plus simultaneous edges:
  - latch with OE = 0 → err_oe = 1.
  - clk_shft and LAT rise on the same clk edge as the 64th pixel → the row includes that pixel and err_len is not set.
- Wrap and read-collision:
  - 256 frames with CNT_W = 8 → frame_cnt returns to 0.
  - rd_row equal to the committing row in the commit cycle → rd_data shows the old contents, then the new contents on the next read.
